psram_qpi_responder: RTL and testbench

//  Device-side responder for the QSPI PSRAM link used by the PSRAM controller. It stands in for the

---
 rtl/psram_qpi_pkg.sv | 23 ++
 rtl/psram_sck_edge.sv | 20 ++
 rtl/psram_qpi_responder.sv | 188 ++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/psram_qpi_pkg.sv
// Shared constants and state encoding for the QSPI PSRAM device-side responder.
package psram_qpi_pkg;

  localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_EXIT_QPI  = 8'hF5;

  // Wide enough for 8 SPI bits or 6 address nibbles.
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPI_CMD,
    ST_QPI_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/psram_sck_edge.sv
// Registers the link clock in the clk_i domain and produces single-cycle rise/fall pulses.
module psram_sck_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck,
  output logic o_rise,
  output logic o_fall
);

  logic r_sck_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_sck_q <= 1'b0;
    else       r_sck_q <= sck;
  end

  assign o_rise = sck & ~r_sck_q;
  assign o_fall = ~sck & r_sck_q;

endmodule

// File: rtl/psram_qpi_responder.sv
// Device-side QSPI PSRAM responder: decodes SPI/QPI commands and maps link traffic to byte accesses.
//  state      | meaning
//  IDLE       | ce_n high, waiting for a transfer
//  SPI_CMD    | shifting 8 command bits on dio_i[0]
//  QPI_CMD    | collecting 2 command nibbles
//  ADDR       | collecting 6 address nibbles
//  WAIT       | dummy cycles before read data
//  RDATA      | driving read nibbles on falls
//  WDATA      | assembling write bytes on rises
//  IGNORE     | transfer finished or unknown, wait for ce_n high
module psram_qpi_responder
  import psram_qpi_pkg::*;
#(
  parameter int RD_WAIT = 6,
  parameter int AW      = 24
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sck,
  input  logic          ce_n,
  input  logic [3:0]    dio_i,
  output logic [3:0]    dio_o,
  output logic [3:0]    dio_oe,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic          qpi_mode
);

  localparam int            WAIT_W   = $clog2(RD_WAIT + 2);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic              w_rise, w_fall;
  logic [7:0]        w_spi_byte, w_qpi_byte, w_rd_byte;
  logic [23:0]       w_addr_full;

  state_t            r_state;
  logic              r_enter, r_exit, r_is_read, r_rd_pend, r_nib_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [6:0]        r_shift;
  logic [19:0]       r_addr_sh;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [7:0]        r_tx;

  psram_sck_edge u_sck_edge (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sck   (sck),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  assign w_spi_byte  = {r_shift, dio_i[0]};
  assign w_qpi_byte  = {r_shift[3:0], dio_i};
  assign w_addr_full = {r_addr_sh, dio_i};
  // Bypass covers a high-nibble fall landing on the same cycle the back-end data is latched.
  assign w_rd_byte   = r_rd_pend ? mem_rdata : r_tx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      qpi_mode   <= 1'b0;
      dio_o      <= 4'h0;
      dio_oe     <= 4'h0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      r_enter    <= 1'b0;
      r_exit     <= 1'b0;
      r_is_read  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_nib_sel  <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_addr_sh  <= '0;
      r_wait_cnt <= '0;
      r_tx       <= 8'h00;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      r_rd_pend <= mem_re;
      if (r_rd_pend) r_tx <= mem_rdata;

      if (ce_n) begin
        if (r_state != ST_IDLE) begin
          r_state <= ST_IDLE;
          dio_oe  <= 4'h0;
          dio_o   <= 4'h0;
          if (r_enter)     qpi_mode <= 1'b1;
          else if (r_exit) qpi_mode <= 1'b0;
          r_enter <= 1'b0;
          r_exit  <= 1'b0;
        end
        r_cnt     <= '0;
        r_nib_sel <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: r_state <= qpi_mode ? ST_QPI_CMD : ST_SPI_CMD;

          ST_SPI_CMD: if (w_rise) begin
            r_shift <= w_spi_byte[6:0];
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(7)) begin
              r_enter <= (w_spi_byte == CMD_ENTER_QPI);
              r_state <= ST_IGNORE;
            end
          end

          ST_QPI_CMD: if (w_rise) begin
            r_shift[3:0] <= dio_i;
            r_cnt        <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              if (w_qpi_byte == CMD_QREAD || w_qpi_byte == CMD_QWRITE) begin
                r_is_read <= (w_qpi_byte == CMD_QREAD);
                r_cnt     <= '0;
                r_state   <= ST_ADDR;
              end else begin
                r_exit  <= (w_qpi_byte == CMD_EXIT_QPI);
                r_state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR: if (w_rise) begin
            r_addr_sh <= w_addr_full[19:0];
            r_cnt     <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(5)) begin
              mem_addr <= w_addr_full[AW-1:0];
              if (r_is_read) begin
                mem_re     <= 1'b1;
                r_wait_cnt <= WAIT_W'(RD_WAIT);
                r_state    <= ST_WAIT;
              end else begin
                r_nib_sel <= 1'b0;
                r_state   <= ST_WDATA;
              end
            end
          end

          ST_WAIT: begin
            if (w_rise && r_wait_cnt != '0) begin
              r_wait_cnt <= r_wait_cnt - 1'b1;
            end else if (w_fall && r_wait_cnt == '0) begin
              dio_oe    <= 4'hF;
              dio_o     <= w_rd_byte[7:4];
              r_nib_sel <= 1'b1;
              r_state   <= ST_RDATA;
            end
          end

          ST_RDATA: if (w_fall) begin
            if (r_nib_sel) begin
              dio_o     <= r_tx[3:0];
              r_nib_sel <= 1'b0;
              mem_addr  <= mem_addr + ADDR_ONE;
              mem_re    <= 1'b1;
            end else begin
              dio_o     <= w_rd_byte[7:4];
              r_nib_sel <= 1'b1;
            end
          end

          ST_WDATA: begin
            if (mem_we) mem_addr <= mem_addr + ADDR_ONE;
            if (w_rise) begin
              if (!r_nib_sel) begin
                r_shift[3:0] <= dio_i;
                r_nib_sel    <= 1'b1;
              end else begin
                mem_wdata <= w_qpi_byte;
                mem_we    <= 1'b1;
                r_nib_sel <= 1'b0;
              end
            end
          end

          ST_IGNORE: ;

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Scoreboard bench for psram_qpi_responder: drives link transfers, models the back-end memory.
module tb_psram_qpi_responder;
  import psram_qpi_pkg::*;

  typedef struct {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sck   = 1'b0;
  logic        ce_n  = 1'b1;
  logic [3:0]  dio_i = 4'h0;
  logic [3:0]  dio_o, dio_oe;
  logic [23:0] mem_addr;
  logic        mem_re, mem_we, qpi_mode;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;

  logic [7:0]  tb_mem [256];
  logic [23:0] exp_re[$];
  wr_t         exp_wr[$];
  logic [3:0]  exp_dio[$];

  int n_vec = 0;
  int n_err = 0;

  psram_qpi_responder #(.RD_WAIT(6), .AW(24)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sck      (sck),
    .ce_n     (ce_n),
    .dio_i    (dio_i),
    .dio_o    (dio_o),
    .dio_oe   (dio_oe),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .qpi_mode (qpi_mode)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Synchronous back-end: data registered on the cycle after the read strobe.
  always @(posedge clk_i) begin
    if (mem_re) mem_rdata <= tb_mem[mem_addr[7:0]];
    if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_re && mem_we) chk("re_we_overlap", 1, 0);
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wdata, w.d);
        end
      end
      if (mem_re) begin
        if (exp_re.size() == 0) chk("re_unexpected", mem_addr, 32'hFFFF_FFFF);
        else chk("re_addr", mem_addr, exp_re.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic [3:0] d);
    dio_i = d;
    repeat (2) @(negedge clk_i);
    sck = 1'b1;
    repeat (2) @(negedge clk_i);
    sck = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic cs_start();
    ce_n = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic cs_end();
    ce_n = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]});
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic qpi_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
  endtask

  task automatic qread(input logic [23:0] a, input int nbytes);
    logic [23:0] na;
    cs_start();
    qpi_byte(CMD_QREAD);
    exp_re.push_back(a);
    qpi_addr(a);
    for (int i = 0; i < 5; i++) pulse(4'h0);
    chk("oe_in_wait", dio_oe, 4'h0);
    pulse(4'h0);
    for (int k = 0; k < 2 * nbytes; k++) begin
      if (k % 2 == 1) begin
        na = a + 24'(k / 2 + 1);
        exp_re.push_back(na);
      end
      if (k > 0) pulse(4'h0);
      if (exp_dio.size() == 0) chk("dio_underflow", dio_o, 32'hFFFF_FFFF);
      else chk("rd_nibble", dio_o, exp_dio.pop_front());
      chk("rd_oe", dio_oe, 4'hF);
    end
    cs_end();
    chk("oe_after_cs", dio_oe, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    tb_mem[8'hFF] = 8'h5A;
    tb_mem[8'h00] = 8'hC3;

    repeat (3) @(negedge clk_i);
    chk("rst_qpi",   qpi_mode,  0);
    chk("rst_dio_o", dio_o,     0);
    chk("rst_oe",    dio_oe,    0);
    chk("rst_re",    mem_re,    0);
    chk("rst_we",    mem_we,    0);
    chk("rst_addr",  mem_addr,  0);
    chk("rst_wdata", mem_wdata, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    cs_start();
    spi_byte(CMD_ENTER_QPI);
    chk("qpi_before_cs", qpi_mode, 0);
    cs_end();
    chk("qpi_enter", qpi_mode, 1);

    exp_wr.push_back('{a: 24'h000010, d: 8'hDE});
    exp_wr.push_back('{a: 24'h000011, d: 8'hAD});
    cs_start();
    qpi_byte(CMD_QWRITE);
    qpi_addr(24'h000010);
    qpi_byte(8'hDE);
    qpi_byte(8'hAD);
    cs_end();
    chk("wr_pending", exp_wr.size(), 0);

    cs_start();
    qpi_byte(CMD_QWRITE);
    qpi_addr(24'h000020);
    pulse(4'h7);
    cs_end();

    exp_dio.push_back(4'hD); exp_dio.push_back(4'hE);
    exp_dio.push_back(4'hA); exp_dio.push_back(4'hD);
    qread(24'h000010, 2);

    exp_dio.push_back(4'h5); exp_dio.push_back(4'hA);
    exp_dio.push_back(4'hC); exp_dio.push_back(4'h3);
    qread(24'hFFFFFF, 2);

    cs_start();
    qpi_byte(CMD_EXIT_QPI);
    chk("qpi_exit_before_cs", qpi_mode, 1);
    cs_end();
    chk("qpi_exit", qpi_mode, 0);

    cs_start();
    spi_byte(CMD_ENTER_QPI);
    cs_end();
    chk("qpi_reenter", qpi_mode, 1);

    cs_start();
    qpi_byte(CMD_QREAD);
    exp_re.push_back(24'h000010);
    qpi_addr(24'h000010);
    for (int i = 0; i < 6; i++) pulse(4'h0);
    chk("rd_before_rst", dio_o, 4'hD);
    chk("oe_before_rst", dio_oe, 4'hF);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_oe",  dio_oe,   0);
    chk("rst_mid_qpi", qpi_mode, 0);
    rst_i = 1'b0;
    ce_n  = 1'b1;
    repeat (3) @(negedge clk_i);

    cs_start();
    spi_byte(CMD_ENTER_QPI);
    cs_end();
    chk("qpi_after_rst", qpi_mode, 1);

    chk("re_left",  exp_re.size(),  0);
    chk("wr_left",  exp_wr.size(),  0);
    chk("dio_left", exp_dio.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
